// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------------------------
// imm_gen_pipe
//   Pipelined immediate generator placed between fetch and decode. Every accepted instruction
//   is decoded on the way in (immediate, format class, illegal-opcode flag and PC-relative
//   target). The decoded entry is then held in a two-entry elastic buffer: an output register
//   (OR) that drives the out_* ports, and a skid register (SK) that absorbs one extra entry.
//   Because of the skid register, in_ready depends only on registered state and never on
//   out_ready.
//
// Parameters
//   XLEN    datapath width, 32 or 64
//   TGT_EN  1: compute o_out_target, 0: o_out_target tied to zero and the adder is removed
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          asynchronous active-high reset
//   i_flush        synchronous flush, drops both buffered entries and the input in that cycle
//   i_in_valid     upstream instruction valid
//   o_in_ready     block can accept this cycle (derived from registered state only)
//   i_in_instr     32-bit instruction word
//   i_in_pc        PC of i_in_instr
//   o_out_valid    out_* fields valid
//   i_out_ready    downstream accepts this cycle
//   o_out_imm      sign-/zero-extended immediate
//   o_out_fmt      0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHIFT, 7 CSR-uimm
//   o_out_target   pc + imm for B, J and AUIPC, otherwise 0
//   o_out_illegal  opcode not recognised for this XLEN
//   o_out_pc       pass-through of i_in_pc
// ---------------------------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned TGT_EN = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [31:0]     i_in_instr,
    input  logic [XLEN-1:0] i_in_pc,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_out_imm,
    output logic [2:0]      o_out_fmt,
    output logic [XLEN-1:0] o_out_target,
    output logic            o_out_illegal,
    output logic [XLEN-1:0] o_out_pc
);

    // -----------------------------------------------------------------------------------------
    // Parameter legality
    // -----------------------------------------------------------------------------------------
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam bit Rv64 = (XLEN == 64);

    // Decoded entry layout: {imm, fmt, target, illegal, pc}
    localparam int unsigned DW = 3 * XLEN + 4;

    localparam logic [2:0] FmtNone  = 3'd0;
    localparam logic [2:0] FmtI     = 3'd1;
    localparam logic [2:0] FmtS     = 3'd2;
    localparam logic [2:0] FmtB     = 3'd3;
    localparam logic [2:0] FmtU     = 3'd4;
    localparam logic [2:0] FmtJ     = 3'd5;
    localparam logic [2:0] FmtShift = 3'd6;
    localparam logic [2:0] FmtCsr   = 3'd7;

    localparam logic [6:0] OpOpImm   = 7'b0010011;
    localparam logic [6:0] OpOpImm32 = 7'b0011011;
    localparam logic [6:0] OpLoad    = 7'b0000011;
    localparam logic [6:0] OpJalr    = 7'b1100111;
    localparam logic [6:0] OpFence   = 7'b0001111;
    localparam logic [6:0] OpStore   = 7'b0100011;
    localparam logic [6:0] OpBranch  = 7'b1100011;
    localparam logic [6:0] OpLui     = 7'b0110111;
    localparam logic [6:0] OpAuipc   = 7'b0010111;
    localparam logic [6:0] OpJal     = 7'b1101111;
    localparam logic [6:0] OpSystem  = 7'b1110011;
    localparam logic [6:0] OpOp      = 7'b0110011;
    localparam logic [6:0] OpOp32    = 7'b0111011;

    // -----------------------------------------------------------------------------------------
    // Immediate extraction, all candidates formed at XLEN width
    // -----------------------------------------------------------------------------------------
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic            w_is_shift;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_shamt;
    logic [XLEN-1:0] w_shamt5;
    logic [XLEN-1:0] w_uimm;

    assign w_opcode   = i_in_instr[6:0];
    assign w_funct3   = i_in_instr[14:12];
    assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

    assign w_imm_i  = XLEN'($signed(i_in_instr[31:20]));
    assign w_imm_s  = XLEN'($signed({i_in_instr[31:25], i_in_instr[11:7]}));
    assign w_imm_b  = XLEN'($signed({i_in_instr[31], i_in_instr[7], i_in_instr[30:25],
                                     i_in_instr[11:8], 1'b0}));
    assign w_imm_u  = XLEN'($signed({i_in_instr[31:12], 12'b0}));
    assign w_imm_j  = XLEN'($signed({i_in_instr[31], i_in_instr[19:12], i_in_instr[20],
                                     i_in_instr[30:21], 1'b0}));
    // funct7 bits (including the SRAI marker bit 30) never reach the shift amount
    assign w_shamt  = Rv64 ? XLEN'(i_in_instr[25:20]) : XLEN'(i_in_instr[24:20]);
    assign w_shamt5 = XLEN'(i_in_instr[24:20]);
    assign w_uimm   = XLEN'(i_in_instr[19:15]);

    // -----------------------------------------------------------------------------------------
    // Opcode decode
    // -----------------------------------------------------------------------------------------
    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_fmt;
    logic            w_illegal;
    logic            w_use_tgt;

    always_comb begin
        w_imm     = '0;
        w_fmt     = FmtNone;
        w_illegal = 1'b0;
        w_use_tgt = 1'b0;
        case (w_opcode)
            OpOpImm: begin
                if (w_is_shift) begin
                    w_fmt = FmtShift;
                    w_imm = w_shamt;
                end else begin
                    w_fmt = FmtI;
                    w_imm = w_imm_i;
                end
            end
            OpOpImm32: begin
                // Word shifts only have a 5-bit shamt even on RV64
                if (!Rv64) begin
                    w_illegal = 1'b1;
                end else if (w_is_shift) begin
                    w_fmt = FmtShift;
                    w_imm = w_shamt5;
                end else begin
                    w_fmt = FmtI;
                    w_imm = w_imm_i;
                end
            end
            OpLoad, OpJalr, OpFence: begin
                w_fmt = FmtI;
                w_imm = w_imm_i;
            end
            OpStore: begin
                w_fmt = FmtS;
                w_imm = w_imm_s;
            end
            OpBranch: begin
                w_fmt     = FmtB;
                w_imm     = w_imm_b;
                w_use_tgt = 1'b1;
            end
            OpLui: begin
                w_fmt = FmtU;
                w_imm = w_imm_u;
            end
            OpAuipc: begin
                w_fmt     = FmtU;
                w_imm     = w_imm_u;
                w_use_tgt = 1'b1;
            end
            OpJal: begin
                w_fmt     = FmtJ;
                w_imm     = w_imm_j;
                w_use_tgt = 1'b1;
            end
            OpSystem: begin
                if (w_funct3[2]) begin
                    w_fmt = FmtCsr;
                    w_imm = w_uimm;
                end else begin
                    w_fmt = FmtI;
                    w_imm = w_imm_i;
                end
            end
            OpOp: begin
                w_fmt = FmtNone;
            end
            OpOp32: begin
                w_illegal = !Rv64;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // PC-relative target, wraps modulo 2^XLEN
    // -----------------------------------------------------------------------------------------
    logic [XLEN-1:0] w_target;

    if (TGT_EN != 0) begin : g_tgt
        assign w_target = w_use_tgt ? (i_in_pc + w_imm) : '0;
    end else begin : g_no_tgt
        assign w_target = '0;
    end

    logic [DW-1:0] w_dec;
    assign w_dec = {w_imm, w_fmt, w_target, w_illegal, i_in_pc};

    // -----------------------------------------------------------------------------------------
    // Two-entry elastic buffer (OR drives the outputs, SK catches the overflow entry)
    // -----------------------------------------------------------------------------------------
    logic          r_or_valid;
    logic          r_sk_valid;
    logic [DW-1:0] r_or_data;
    logic [DW-1:0] r_sk_data;
    logic          w_accept;
    logic          w_out_fire;

    assign o_in_ready  = ~r_sk_valid;
    assign o_out_valid = r_or_valid;
    assign w_accept    = i_in_valid & ~r_sk_valid;
    assign w_out_fire  = r_or_valid & i_out_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_or_valid <= 1'b0;
            r_sk_valid <= 1'b0;
            r_or_data  <= '0;
            r_sk_data  <= '0;
        end else if (i_flush) begin
            r_or_valid <= 1'b0;
            r_sk_valid <= 1'b0;
        end else if (w_out_fire && r_sk_valid) begin
            // SK full implies in_ready was low, so no accept can coincide with this move
            r_or_data  <= r_sk_data;
            r_sk_valid <= 1'b0;
        end else if (w_accept) begin
            if (!r_or_valid || w_out_fire) begin
                r_or_data  <= w_dec;
                r_or_valid <= 1'b1;
            end else begin
                r_sk_data  <= w_dec;
                r_sk_valid <= 1'b1;
            end
        end else if (w_out_fire) begin
            r_or_valid <= 1'b0;
        end
    end

    assign {o_out_imm, o_out_fmt, o_out_target, o_out_illegal, o_out_pc} = r_or_data;

endmodule
